// File: rtl/gray_histogram.sv
// gray_histogram
//   Per-frame luminance histogram. Accumulates one video frame of gray pixels
//   into a 2^COLORDEPTH x BINWIDTH RAM, then presents the bins one at a time
//   over a ready/saved handshake. After the last bin is taken, the RAM is
//   cleared and the block re-arms for the next frame.
//
// Ports
//   clk            pixel clock
//   rst            asynchronous active-low reset
//   pix_i          gray pixel value, used as the bin address
//   dv_i           pixel valid
//   vs_i           vertical sync, active-high
//   hist_bin_data  count of bin hist_bin_idx, valid while hist_bin_ready=1
//   hist_bin_idx   index of the presented bin
//   hist_bin_ready bin presented, waiting for the consumer
//   hist_bin_saved consumer has taken the current bin
//   frame_done_o   one-cycle pulse after the last bin is taken
//   sat_o          some bin saturated in the last captured frame
module gray_histogram #(
  parameter int COLORDEPTH = 8,
  parameter int BINWIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] pix_i,
  input  logic                  dv_i,
  input  logic                  vs_i,
  output logic [BINWIDTH-1:0]   hist_bin_data,
  output logic [COLORDEPTH-1:0] hist_bin_idx,
  output logic                  hist_bin_ready,
  input  logic                  hist_bin_saved,
  output logic                  frame_done_o,
  output logic                  sat_o
);
  localparam int NBINS = 2 ** COLORDEPTH;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_ARMED,
    S_ACCUM,
    S_DRAIN,
    S_READOUT
  } state_t;

  state_t state_q, state_d;

  logic [BINWIDTH-1:0]   ram [NBINS];
  logic [BINWIDTH-1:0]   ram_q;
  logic [COLORDEPTH-1:0] clr_addr;
  logic                  drain_cnt;
  logic                  vs_q;
  logic                  vs_fall, vs_rise;
  logic                  cap;
  logic                  s1_v, s2_v;
  logic [COLORDEPTH-1:0] s1_a, s2_a;
  logic                  byp_q;
  logic [BINWIDTH-1:0]   byp_d;
  logic [BINWIDTH-1:0]   cur, inc;
  logic                  inc_sat;
  logic                  we;
  logic [COLORDEPTH-1:0] wa, ra;
  logic [BINWIDTH-1:0]   wd;
  logic                  rd_pend;
  logic                  accept;

  assign vs_fall = vs_q & ~vs_i;
  assign vs_rise = ~vs_q & vs_i;
  assign accept  = (state_q == S_READOUT) & hist_bin_ready & hist_bin_saved;
  assign cap     = dv_i & (((state_q == S_ARMED) & vs_fall) | (state_q == S_ACCUM));

  // A write landing on the same edge as the read of the same address is
  // returned through the bypass register instead of the stale RAM word; this
  // covers both back-to-back and one-apart hits on one bin.
  assign cur     = byp_q ? byp_d : ram_q;
  assign inc_sat = &cur;
  assign inc     = inc_sat ? cur : cur + BINWIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_CLEAR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLEAR:   if (&clr_addr) state_d = S_ARMED;
      S_ARMED:   if (vs_fall) state_d = S_ACCUM;
      S_ACCUM:   if (vs_rise) state_d = S_DRAIN;
      S_DRAIN:   if (drain_cnt) state_d = S_READOUT;
      S_READOUT: if (accept && (&hist_bin_idx)) state_d = S_CLEAR;
      default:   state_d = S_CLEAR;
    endcase
  end

  // Single write port shared by clearing and accumulation; read port shared
  // by the RMW pipeline and readout. Readout pre-issues the next bin's read
  // on the accept cycle so bins stream at one per two cycles.
  always_comb begin
    we = 1'b0;
    wa = s2_a;
    wd = inc;
    if (state_q == S_CLEAR) begin
      we = 1'b1;
      wa = clr_addr;
      wd = '0;
    end else if (s2_v) begin
      we = 1'b1;
    end
    ra = s1_a;
    if (state_q == S_READOUT)
      ra = accept ? hist_bin_idx + COLORDEPTH'(1) : hist_bin_idx;
  end

  always_ff @(posedge clk) begin
    if (we) ram[wa] <= wd;
    ram_q <= ram[ra];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q      <= 1'b0;
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s2_v      <= 1'b0;
      s2_a      <= '0;
      byp_q     <= 1'b0;
      byp_d     <= '0;
      clr_addr  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      vs_q      <= vs_i;
      s1_v      <= cap;
      s1_a      <= pix_i;
      s2_v      <= s1_v;
      s2_a      <= s1_a;
      byp_q     <= we && (wa == ra);
      byp_d     <= wd;
      clr_addr  <= (state_q == S_CLEAR) ? clr_addr + COLORDEPTH'(1) : '0;
      drain_cnt <= (state_q == S_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_bin_data  <= '0;
      hist_bin_idx   <= '0;
      hist_bin_ready <= 1'b0;
      rd_pend        <= 1'b0;
      frame_done_o   <= 1'b0;
      sat_o          <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (state_q == S_CLEAR)    sat_o <= 1'b0;
      else if (s2_v && inc_sat)  sat_o <= 1'b1;
      if (state_q == S_READOUT) begin
        if (rd_pend) begin
          hist_bin_data  <= cur;
          hist_bin_ready <= 1'b1;
          rd_pend        <= 1'b0;
        end else if (accept) begin
          hist_bin_ready <= 1'b0;
          hist_bin_idx   <= hist_bin_idx + COLORDEPTH'(1);
          rd_pend        <= ~(&hist_bin_idx);
          frame_done_o   <= &hist_bin_idx;
        end else if (!hist_bin_ready) begin
          rd_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_histogram.sv
module tb_gray_histogram;
  localparam int CD = 8;
  localparam int BW = 16;
  localparam int NB = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [CD-1:0] pix_i;
  logic          dv_i;
  logic          vs_i;
  logic [BW-1:0] hist_bin_data;
  logic [CD-1:0] hist_bin_idx;
  logic          hist_bin_ready;
  logic          hist_bin_saved;
  logic          frame_done_o;
  logic          sat_o;

  always #5 clk = ~clk;

  gray_histogram #(.COLORDEPTH(CD), .BINWIDTH(BW)) dut (
    .clk(clk), .rst(rst), .pix_i(pix_i), .dv_i(dv_i), .vs_i(vs_i),
    .hist_bin_data(hist_bin_data), .hist_bin_idx(hist_bin_idx),
    .hist_bin_ready(hist_bin_ready), .hist_bin_saved(hist_bin_saved),
    .frame_done_o(frame_done_o), .sat_o(sat_o)
  );

  typedef struct packed {logic dv; logic [7:0] pix;} px_t;

  typedef struct {
    logic [7:0]  pix [8];
    int unsigned len;
    logic [7:0]  bin_a;
    int unsigned cnt_a;
    logic [7:0]  bin_b;
    int unsigned cnt_b;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned model [NB];
  bit          model_sat;
  int unsigned got [NB];
  px_t         fq [$];
  vec_t        tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pix(input logic [7:0] p);
    if (model[p] == 65535) model_sat = 1'b1;
    else model[p] = model[p] + 1;
  endtask

  // Frame: vs falls with the first queued entry, stays low for the queue,
  // then rises for one cycle that may carry a pixel of its own.
  task automatic send_frame(input bit rise_dv, input logic [7:0] rise_pix);
    foreach (model[i]) model[i] = 0;
    model_sat = 1'b0;
    foreach (fq[i]) begin
      vs_i = 1'b0; dv_i = fq[i].dv; pix_i = fq[i].pix;
      if (fq[i].dv) model_pix(fq[i].pix);
      tick();
    end
    vs_i = 1'b1; dv_i = rise_dv; pix_i = rise_pix;
    if (rise_dv) model_pix(rise_pix);
    tick();
    dv_i = 1'b0;
  endtask

  task automatic wait_clear();
    vs_i = 1'b1; dv_i = 1'b0;
    repeat (260) tick();
  endtask

  // mode 0: saved held high; 1: random saved; 2: random saved plus a whole
  // frame driven during readout; 3: saved held high, reset at bin 100.
  task automatic read_all(input int mode);
    int unsigned exp_idx = 0;
    int          cyc = 0;
    int          t_first = -1;
    bit          done = 1'b0;
    bit          have_last = 1'b0;
    bit          sav;
    logic [15:0] last_data = '0;
    hist_bin_saved = (mode == 0 || mode == 3);
    while (!done && cyc < 6000) begin
      tick(); cyc++;
      sav = (mode == 0 || mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (frame_done_o) begin
        check("done_ready_low", hist_bin_ready, 0);
        check("done_bin_count", exp_idx, 256);
        if (mode == 0) check("readout_span", cyc - t_first, 511);
        done = 1'b1;
      end else if (hist_bin_ready) begin
        if (t_first < 0) begin
          t_first = cyc;
          check("first_ready_latency", cyc, 4);
          check("sat_flag", sat_o, model_sat);
        end
        check("bin_idx", hist_bin_idx, exp_idx);
        check("bin_data", hist_bin_data, model[exp_idx[7:0]]);
        got[exp_idx[7:0]] = hist_bin_data;
        if (mode == 3 && exp_idx == 100) begin
          rst = 1'b0;
          #1;
          check("rst_data", hist_bin_data, 0);
          check("rst_idx", hist_bin_idx, 0);
          check("rst_ready", hist_bin_ready, 0);
          check("rst_done", frame_done_o, 0);
          check("rst_sat", sat_o, 0);
          hist_bin_saved = 1'b0;
          return;
        end
        if (sav) begin
          exp_idx++;
          last_data = hist_bin_data;
          have_last = 1'b1;
        end
      end else if (have_last) begin
        check("data_hold", hist_bin_data, last_data);
      end
      hist_bin_saved = sav;
      if (mode == 2) begin
        vs_i  = !(cyc >= 30 && cyc < 200);
        dv_i  = 1'($urandom_range(0, 1));
        pix_i = 8'($urandom);
      end
    end
    hist_bin_saved = 1'b0; vs_i = 1'b1; dv_i = 1'b0;
    if (!done) begin
      check("readout_timeout", 0, 1);
    end else begin
      tick();
      check("done_single_pulse", frame_done_o, 0);
    end
  endtask

  initial begin
    int n;
    tbl[0].pix = '{8'd7, 8'd7, 8'd8, 8'd7, 8'd7, 8'd7, 8'd0, 8'd0};
    tbl[0].len = 6; tbl[0].bin_a = 8'd7;   tbl[0].cnt_a = 5; tbl[0].bin_b = 8'd8; tbl[0].cnt_b = 1;
    tbl[1].pix = '{8'd7, 8'd8, 8'd7, 8'd8, 8'd7, 8'd8, 8'd8, 8'd0};
    tbl[1].len = 7; tbl[1].bin_a = 8'd7;   tbl[1].cnt_a = 3; tbl[1].bin_b = 8'd8; tbl[1].cnt_b = 4;
    tbl[2].pix = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    tbl[2].len = 8; tbl[2].bin_a = 8'd3;   tbl[2].cnt_a = 8; tbl[2].bin_b = 8'd4; tbl[2].cnt_b = 0;
    tbl[3].pix = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    tbl[3].len = 4; tbl[3].bin_a = 8'd255; tbl[3].cnt_a = 2; tbl[3].bin_b = 8'd0; tbl[3].cnt_b = 2;

    rst = 1'b0; vs_i = 1'b1; dv_i = 1'b0; pix_i = '0; hist_bin_saved = 1'b0;
    repeat (3) tick();
    check("reset_data", hist_bin_data, 0);
    check("reset_idx", hist_bin_idx, 0);
    check("reset_ready", hist_bin_ready, 0);
    check("reset_done", frame_done_o, 0);
    check("reset_sat", sat_o, 0);
    rst = 1'b1;
    repeat (256) tick();

    // 16 back-to-back pixels of 5, vs falling on the first ARMED cycle
    fq.delete();
    repeat (16) fq.push_back('{1'b1, 8'd5});
    send_frame(1'b0, 8'd0);
    read_all(0);
    check("t1_bin5", got[5], 16);
    check("t1_bin6", got[6], 0);
    wait_clear();

    // hazard vectors at full duty
    for (int unsigned v = 0; v < 4; v++) begin
      fq.delete();
      for (int unsigned k = 0; k < tbl[v].len; k++) fq.push_back('{1'b1, tbl[v].pix[k]});
      send_frame(1'b0, 8'd0);
      read_all(0);
      check("tbl_bin_a", got[tbl[v].bin_a], tbl[v].cnt_a);
      check("tbl_bin_b", got[tbl[v].bin_b], tbl[v].cnt_b);
      wait_clear();
    end

    // ramp with random gaps, random consumer
    fq.delete();
    for (int p = 0; p < 256; p++) begin
      repeat ($urandom_range(0, 2)) fq.push_back('{1'b0, 8'($urandom)});
      fq.push_back('{1'b1, 8'(p)});
    end
    send_frame(1'b0, 8'd0);
    read_all(1);
    n = 0;
    for (int b = 0; b < NB; b++) if (got[b] == 1) n++;
    check("ramp_ones", n, 256);
    wait_clear();

    // random dense frame with a pixel on the vs rise; a frame is driven
    // during readout and must be dropped
    fq.delete();
    repeat (400) fq.push_back('{1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 15))});
    send_frame(1'b1, 8'd3);
    read_all(2);
    wait_clear();
    fq.delete();
    repeat (10) fq.push_back('{1'b1, 8'($urandom_range(0, 15))});
    send_frame(1'b0, 8'd0);
    read_all(0);
    wait_clear();

    // saturation, then a fresh frame clears it
    fq.delete();
    repeat (70000) fq.push_back('{1'b1, 8'd0});
    send_frame(1'b0, 8'd0);
    read_all(0);
    check("sat_bin0", got[0], 65535);
    wait_clear();
    fq.delete();
    fq.push_back('{1'b1, 8'd0});
    send_frame(1'b0, 8'd0);
    read_all(0);
    check("post_sat_bin0", got[0], 1);
    wait_clear();

    // reset during readout, then a frame attempted one cycle before ARMED
    fq.delete();
    repeat (8) fq.push_back('{1'b1, 8'($urandom_range(90, 110))});
    send_frame(1'b0, 8'd0);
    read_all(3);
    repeat (2) tick();
    rst = 1'b1;
    repeat (255) tick();
    vs_i = 1'b0; dv_i = 1'b1; pix_i = 8'd77;
    tick();
    vs_i = 1'b1; dv_i = 1'b0;
    tick();
    fq.delete();
    repeat (4) fq.push_back('{1'b1, 8'd200});
    send_frame(1'b0, 8'd0);
    read_all(0);
    check("rst_bin200", got[200], 4);
    check("rst_bin100", got[100], 0);
    check("early_bin77", got[77], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_histogram.md
# gray_histogram

Per-frame 256-bin luminance histogram for the HDMI video pipeline. Sits downstream of the grayscale/blur/Sobel chain inside the top-level filter block. It consumes the selected 8-bit gray stream with its dv/vs qualifiers and accumulates one frame into an internal 256×16 RAM. After the frame ends, it exposes the bins one at a time to the readout side through the `hist_bin_data` / `hist_bin_ready` / `hist_bin_saved` handshake.

## Interface
- `COLORDEPTH`, 8: pixel width; bin count is 2^COLORDEPTH (256).
- `BINWIDTH`, 16: bin counter width.
- `clk`  in  1  pixel clock; only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `pix_i`  in  COLORDEPTH  gray pixel value (bin address).
- `dv_i`  in  1  pixel valid.
- `vs_i`  in  1  vertical sync, active-high (polarity already normalised upstream).
- `hist_bin_data`  out  BINWIDTH  count of bin `hist_bin_idx`; valid while `hist_bin_ready`=1.
- `hist_bin_idx`  out  COLORDEPTH  index of presented bin.
- `hist_bin_ready`  out  1  bin presented, waiting for consumer.
- `hist_bin_saved`  in  1  consumer has taken current bin.
- `frame_done_o`  out  1  one-cycle pulse when bin 255 is accepted.
- `sat_o`  out  1  some bin saturated in the last captured frame; valid through READOUT.

## Operation
- States: CLEAR → ARMED → ACCUM → DRAIN → READOUT → CLEAR.
- CLEAR: writes 0 to addresses 0..255, one per cycle (256 cycles). Then ARMED. Clears `sat_o`.
- ARMED: waits for a vs_i falling edge (1→0). That edge enters ACCUM; that cycle's pixel counts if dv_i=1.
- ACCUM: every cycle with dv_i=1 increments bin[pix_i] by 1, saturating at 2^BINWIDTH−1. A saturating increment sets `sat_o`.
- Read-modify-write pipeline: address/valid register, RAM read (1-cycle latency), then add and write.
  - Back-to-back and 1-apart hits on the same bin are forwarded from the write stage.
  - Counts are exact for any dv_i pattern, including 100% duty.
- vs_i rising edge in ACCUM → DRAIN. A pixel with dv_i=1 on that edge cycle is counted.
- DRAIN: lasts until the pipeline is empty (fixed 2 cycles), then READOUT with index 0.
- READOUT: issue RAM read of `hist_bin_idx`; next cycle `hist_bin_data` is loaded and `hist_bin_ready`=1.
  - `hist_bin_saved` is sampled only while `hist_bin_ready`=1.
  - On sample: ready drops next cycle, index increments, next bin is read.
  - After bin 255 is sampled: `frame_done_o` pulses, → CLEAR.
- dv_i/vs_i activity outside ARMED/ACCUM is ignored. Frames arriving during DRAIN/READOUT/CLEAR are dropped whole. A vs edge seen mid-frame never starts a partial capture except via the ARMED rule.

## Timing
- Reset (async assert, sync release) values:
  - `hist_bin_data`=0, `hist_bin_idx`=0, `hist_bin_ready`=0, `frame_done_o`=0, `sat_o`=0.
  - State=CLEAR; RAM is treated as unknown and cleared.
  - Reset mid-ACCUM or mid-READOUT discards everything.
- First ARMED cycle is 256 cycles after reset release.
- Pixel-to-RAM latency is 3 cycles. Bin values are final 2 cycles after the vs rising edge.
- First `hist_bin_ready` rise is 2 cycles after entering READOUT (read issue + data load).
- Bin throughput is at most one bin per 2 cycles. `hist_bin_saved` held high continuously gives a ready pattern of 1,0,1,0… and advances one bin per ready-high cycle.
- Minimum full readout is 512 cycles, then 256 cycles of CLEAR.
- `frame_done_o` is high in the cycle after the bin-255 sample, concurrent with ready=0.
- `hist_bin_data` holds its value while ready=0 and is updated only on load.

## Test plan
- Reset, wait 256+ cycles, frame of 16 back-to-back pixels of value 5 → ready rises; bin5=16, all other bins 0; `sat_o`=0; `frame_done_o` pulses once after bin 255.
- Ramp 0..255, one pixel each, with random dv_i gaps → all 256 bins read as 1; `hist_bin_idx` increments 0..255 in order.
- Hazard pattern 7,7,8,7,7,7 at full duty → bin7=5, bin8=1.
- 70000 consecutive pixels of value 0 → bin0=65535, `sat_o`=1; next frame after CLEAR with 1 pixel of value 0 → bin0=1, `sat_o`=0.
- Handshake:
  - `hist_bin_saved` pulsed while ready=0 → ignored, index unchanged.
  - saved held high → one bin per 2 cycles.
  - A full second frame on vs/dv during READOUT → dropped; readout values unchanged.
- `rst` asserted at bin 100 of READOUT → all outputs 0 immediately; after CLEAR, a frame of 4 pixels of value 200 reads bin200=4, bin100=0.
